multicycle_ctrl: RTL and testbench

Multi-cycle control unit for the RV32I core. It is the sequential successor to the single-cycle decoder. It sequences every instruction through FETCH/DECODE/EXECUTE/MEM/WB states and handshakes with instruction and data memories that have variable latency. It sits between the instruction register and the datapath: it drives datapath select lines, write enables and memory requests, and it flags illegal opcodes and memory timeouts.

---
 rtl/multicycle_ctrl.sv | 251 +++++++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I control unit: sequences FETCH/DECODE/EXECUTE/MEM/WB with variable-latency memory handshakes.
// Define MULTICYCLE_CTRL_TIMEOUT_EN to fault when a memory wait reaches MEM_WAIT_MAX cycles.
module multicycle_ctrl #(
  parameter int unsigned MEM_WAIT_MAX = 15,
  parameter int unsigned WAIT_CW      = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic [2:0] func3,
  input  logic       func7,
  output logic       imem_req,
  input  logic       imem_ready,
  output logic       dmem_req,
  output logic       dmem_we,
  input  logic       dmem_ready,
  output logic       ir_we,
  output logic       pc_we,
  output logic       reg_write,
  output logic       mem_reg,
  output logic       opB,
  output logic       branch,
  output logic [1:0] opA,
  output logic [1:0] imm_sel,
  output logic [1:0] next_sel,
  output logic [3:0] ALU_C,
  output logic [2:0] state,
  output logic       fault
);

  typedef enum logic [2:0] {
    S_FETCH   = 3'd0,
    S_DECODE  = 3'd1,
    S_EXECUTE = 3'd2,
    S_MEM     = 3'd3,
    S_WB      = 3'd4,
    S_FAULT   = 3'd5
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLL  = 4'b0101;
  localparam logic [3:0] ALU_SRL  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_SLTU = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1001;

  // Operand A: rs1 / PC / zero.  Immediate: I / S / U / PC-relative branch-jump offset.
  localparam logic [1:0] OPA_RS1  = 2'b00;
  localparam logic [1:0] OPA_PC   = 2'b01;
  localparam logic [1:0] OPA_ZERO = 2'b10;
  localparam logic [1:0] IMM_I    = 2'b00;
  localparam logic [1:0] IMM_S    = 2'b01;
  localparam logic [1:0] IMM_U    = 2'b10;
  localparam logic [1:0] IMM_BJ   = 2'b11;
  localparam logic [1:0] NEXT_SEQ = 2'b00;
  localparam logic [1:0] NEXT_ALU = 2'b01;
  localparam logic [1:0] NEXT_JAL = 2'b10;
  localparam logic [1:0] NEXT_BR  = 2'b11;

  function automatic logic [3:0] alu_sel(input logic [2:0] f3, input logic alt_add,
                                         input logic alt_shift);
    case (f3)
      3'b000:  return alt_add ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt_shift ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  state_t     r_state, w_next;
  logic       w_legal, w_opb;
  logic [1:0] w_opa, w_imm, w_next_sel;
  logic [3:0] w_alu;
  logic       w_is_load, w_is_store;
  logic       w_imem_req, w_ir_we, w_dmem_req, w_dmem_we, w_pc_we, w_reg_write;
  logic       w_mem_reg, w_branch, w_dp_en, w_timeout;

  assign w_is_load  = (opcode == OP_LOAD);
  assign w_is_store = (opcode == OP_STORE);

  // Datapath select decode; only driven onto the outputs in EXECUTE and MEM.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    w_legal = 1'b1;
    w_opa   = OPA_RS1;
    w_opb   = 1'b1;
    w_imm   = IMM_I;
    w_alu   = ALU_ADD;
    case (opcode)
      OP_R: begin
        w_opb   = 1'b0;
        w_alu   = alu_sel(func3, func7, func7);
        w_legal = !func7 || (func3 == 3'b000) || (func3 == 3'b101);
      end
      OP_I:            w_alu = alu_sel(func3, 1'b0, func7);
      OP_LOAD, OP_JALR: begin end
      OP_STORE:        w_imm = IMM_S;
      OP_BRANCH: begin
        w_opb = 1'b0;
        w_imm = IMM_BJ;
        w_alu = ALU_SUB;
      end
      OP_JAL: begin
        w_opa = OPA_PC;
        w_imm = IMM_BJ;
      end
      OP_LUI: begin
        w_opa = OPA_ZERO;
        w_imm = IMM_U;
      end
      OP_AUIPC: begin
        w_opa = OPA_PC;
        w_imm = IMM_U;
      end
      default:         w_legal = 1'b0;
    endcase
  end

`ifdef MULTICYCLE_CTRL_TIMEOUT_EN
  logic [WAIT_CW-1:0] r_wait;
  logic               w_waiting;

  assign w_waiting = ((r_state == S_FETCH) && !imem_ready) ||
                     ((r_state == S_MEM) && !dmem_ready);
  assign w_timeout = w_waiting && (r_wait == WAIT_CW'(MEM_WAIT_MAX));

  // Restart the count on every entry into a waiting state; saturate rather than wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wait <= '0;
    end else if ((w_next != r_state) && ((w_next == S_FETCH) || (w_next == S_MEM))) begin
      r_wait <= '0;
    end else if (w_waiting && (r_wait != {WAIT_CW{1'b1}})) begin
      r_wait <= r_wait + 1'b1;
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  always_comb begin
    w_next      = r_state;
    w_imem_req  = 1'b0;
    w_ir_we     = 1'b0;
    w_dmem_req  = 1'b0;
    w_dmem_we   = 1'b0;
    w_pc_we     = 1'b0;
    w_reg_write = 1'b0;
    w_mem_reg   = 1'b0;
    w_branch    = 1'b0;
    w_dp_en     = 1'b0;
    w_next_sel  = NEXT_SEQ;
    case (r_state)
      S_FETCH: begin
        w_imem_req = 1'b1;
        if (imem_ready) begin
          w_ir_we = 1'b1;
          w_next  = S_DECODE;
        end else if (w_timeout) begin
          w_next = S_FAULT;
        end
      end
      S_DECODE: w_next = w_legal ? S_EXECUTE : S_FAULT;
      S_EXECUTE: begin
        w_dp_en = 1'b1;
        case (opcode)
          OP_LOAD, OP_STORE: w_next = S_MEM;
          OP_BRANCH: begin
            w_branch   = 1'b1;
            w_pc_we    = 1'b1;
            w_next_sel = NEXT_BR;
            w_next     = S_FETCH;
          end
          OP_JAL: begin
            w_reg_write = 1'b1;
            w_pc_we     = 1'b1;
            w_next_sel  = NEXT_JAL;
            w_next      = S_FETCH;
          end
          OP_JALR: begin
            w_reg_write = 1'b1;
            w_pc_we     = 1'b1;
            w_next_sel  = NEXT_ALU;
            w_next      = S_FETCH;
          end
          default: w_next = S_WB;
        endcase
      end
      S_MEM: begin
        w_dp_en    = 1'b1;
        w_dmem_req = 1'b1;
        w_dmem_we  = w_is_store;
        if (dmem_ready) begin
          w_pc_we = w_is_store;
          w_next  = w_is_store ? S_FETCH : S_WB;
        end else if (w_timeout) begin
          w_next = S_FAULT;
        end
      end
      S_WB: begin
        w_reg_write = 1'b1;
        w_pc_we     = 1'b1;
        w_mem_reg   = w_is_load;
        w_next      = S_FETCH;
      end
      default: w_next = S_FAULT;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (rst) r_state <= S_FETCH;
    else     r_state <= w_next;
  end

  // Reset gates every output combinationally so nothing escapes during the reset cycles.
  assign imem_req  = w_imem_req  & ~rst;
  assign ir_we     = w_ir_we     & ~rst;
  assign dmem_req  = w_dmem_req  & ~rst;
  assign dmem_we   = w_dmem_we   & ~rst;
  assign pc_we     = w_pc_we     & ~rst;
  assign reg_write = w_reg_write & ~rst;
  assign mem_reg   = w_mem_reg   & ~rst;
  assign branch    = w_branch    & ~rst;
  assign opB       = w_opb & w_dp_en & ~rst;
  assign opA       = (w_dp_en && !rst) ? w_opa : 2'b00;
  assign imm_sel   = (w_dp_en && !rst) ? w_imm : 2'b00;
  assign ALU_C     = (w_dp_en && !rst) ? w_alu : 4'b0000;
  assign next_sel  = rst ? 2'b00 : w_next_sel;
  assign state     = rst ? 3'd0 : r_state;
  assign fault     = (r_state == S_FAULT) && !rst;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: a per-instruction timeline model predicts every output each cycle.
`timescale 1ns/1ps
module tb_multicycle_ctrl;

  localparam int MAXW = 4;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] opcode = 7'd0;
  logic [2:0] func3 = 3'd0;
  logic       func7 = 1'b0;
  logic       imem_ready = 1'b0, dmem_ready = 1'b0;
  logic       imem_req, dmem_req, dmem_we, ir_we, pc_we, reg_write, mem_reg, opB, branch, fault;
  logic [1:0] opA, imm_sel, next_sel;
  logic [3:0] ALU_C;
  logic [2:0] state;

  always #5 clk = ~clk;

  multicycle_ctrl #(.MEM_WAIT_MAX(MAXW), .WAIT_CW(8)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .func3(func3), .func7(func7),
    .imem_req(imem_req), .imem_ready(imem_ready), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_ready(dmem_ready), .ir_we(ir_we), .pc_we(pc_we), .reg_write(reg_write),
    .mem_reg(mem_reg), .opB(opB), .branch(branch), .opA(opA), .imm_sel(imm_sel),
    .next_sel(next_sel), .ALU_C(ALU_C), .state(state), .fault(fault)
  );

  typedef struct packed {
    logic [2:0] state;
    logic imem_req, ir_we, dmem_req, dmem_we, pc_we, reg_write, mem_reg, opB, branch, fault;
    logic [1:0] opA, imm_sel, next_sel;
    logic [3:0] alu_c;
  } outs_t;

  typedef enum {P_RESET, P_FETCH, P_DECODE, P_EXEC, P_MEM, P_WB, P_FAULT} phase_t;

  outs_t act, exp_o;
  assign act = {state, imem_req, ir_we, dmem_req, dmem_we, pc_we, reg_write, mem_reg, opB,
                branch, fault, opA, imm_sel, next_sel, ALU_C};

  int    checks = 0, errors = 0;
  bit    exp_valid = 1'b0;
  string tag = "reset";
  int    n_cyc, cnt_ir, cnt_pc, cnt_rw;
  logic [3:0] last_alu;
  logic [1:0] last_opa, last_ns;
  logic       last_mr;
  logic [3:0] alu_tab [16];

  // Single compare process: every cycle with a prediction is checked mid-cycle.
  always @(negedge clk) begin
    if (exp_valid) begin
      checks++;
      if (act !== exp_o) begin
        errors++;
        $display("FAIL ctrl[%s] t=%0t act=%b exp=%b (state act=%0d exp=%0d)",
                 tag, $time, act, exp_o, act.state, exp_o.state);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  function automatic outs_t with_dp(input outs_t o_in, input logic [6:0] op,
                                    input logic [2:0] f3, input logic f7);
    outs_t o = o_in;
    case (op)
      OP_R:      begin o.alu_c = alu_tab[{f7, f3}]; end
      OP_I:      begin o.opB = 1; o.alu_c = alu_tab[{(f3 == 3'b101) & f7, f3}]; end
      OP_LOAD:   begin o.opB = 1; end
      OP_STORE:  begin o.opB = 1; o.imm_sel = 2'b01; end
      OP_BRANCH: begin o.imm_sel = 2'b11; o.alu_c = 4'b0001; end
      OP_JAL:    begin o.opA = 2'b01; o.opB = 1; o.imm_sel = 2'b11; end
      OP_JALR:   begin o.opB = 1; end
      OP_LUI:    begin o.opA = 2'b10; o.opB = 1; o.imm_sel = 2'b10; end
      OP_AUIPC:  begin o.opA = 2'b01; o.opB = 1; o.imm_sel = 2'b10; end
      default:   begin end
    endcase
    return o;
  endfunction

  function automatic outs_t model(input phase_t ph, input logic [6:0] op, input logic [2:0] f3,
                                  input logic f7, input logic rdy);
    outs_t o = '0;
    case (ph)
      P_FETCH:  begin o.imem_req = 1; o.ir_we = rdy; end
      P_DECODE: o.state = 3'd1;
      P_EXEC: begin
        o = with_dp(o, op, f3, f7);
        o.state = 3'd2;
        if (op == OP_BRANCH) begin o.branch = 1; o.pc_we = 1; o.next_sel = 2'b11; end
        if (op == OP_JAL)    begin o.reg_write = 1; o.pc_we = 1; o.next_sel = 2'b10; end
        if (op == OP_JALR)   begin o.reg_write = 1; o.pc_we = 1; o.next_sel = 2'b01; end
      end
      P_MEM: begin
        o = with_dp(o, op, f3, f7);
        o.state    = 3'd3;
        o.dmem_req = 1;
        o.dmem_we  = (op == OP_STORE);
        o.pc_we    = rdy && (op == OP_STORE);
      end
      P_WB:    begin o.state = 3'd4; o.reg_write = 1; o.pc_we = 1; o.mem_reg = (op == OP_LOAD); end
      P_FAULT: begin o.state = 3'd5; o.fault = 1; end
      default: begin end
    endcase
    return o;
  endfunction

  // One clock of stimulus: drive after the edge, publish the prediction, tally pulses mid-cycle.
  task automatic step(input phase_t ph, input logic [6:0] op, input logic [2:0] f3,
                      input logic f7, input logic irdy, input logic drdy);
    @(posedge clk);
    #1;
    rst        = (ph == P_RESET);
    imem_ready = irdy;
    dmem_ready = drdy;
    if (ph != P_FETCH) begin
      opcode = op;
      func3  = f3;
      func7  = f7;
    end
    exp_o     = model(ph, op, f3, f7, (ph == P_MEM) ? drdy : irdy);
    exp_valid = 1'b1;
    @(negedge clk);
    #1;
    n_cyc++;
    cnt_ir += int'(ir_we);
    cnt_pc += int'(pc_we);
    cnt_rw += int'(reg_write);
    if (ph == P_EXEC) begin last_alu = ALU_C; last_opa = opA; last_ns = next_sel; end
    if (ph == P_WB) last_mr = mem_reg;
  endtask

  task automatic clear_tallies(input string name);
    tag = name; n_cyc = 0; cnt_ir = 0; cnt_pc = 0; cnt_rw = 0;
  endtask

  task automatic run_instr(input string name, input logic [6:0] op, input logic [2:0] f3,
                           input logic f7, input int fw, input int mw, input logic noise,
                           input int want_cyc);
    bit mem_ph = (op == OP_LOAD) || (op == OP_STORE);
    bit wb_ph  = !((op == OP_STORE) || (op == OP_BRANCH) || (op == OP_JAL) || (op == OP_JALR));
    clear_tallies(name);
    for (int i = 0; i <= fw; i++) step(P_FETCH, op, f3, f7, i == fw, noise);
    step(P_DECODE, op, f3, f7, noise, noise);
    step(P_EXEC, op, f3, f7, noise, noise);
    if (mem_ph) for (int j = 0; j <= mw; j++) step(P_MEM, op, f3, f7, noise, j == mw);
    if (wb_ph) step(P_WB, op, f3, f7, noise, noise);
    check({name, "_cycles"}, n_cyc, want_cyc);
    check({name, "_ir_we"}, cnt_ir, 1);
    check({name, "_pc_we"}, cnt_pc, 1);
    check({name, "_reg_write"}, cnt_rw, ((op == OP_STORE) || (op == OP_BRANCH)) ? 0 : 1);
  endtask

  task automatic fault_run(input string name, input logic [6:0] op, input logic [2:0] f3,
                           input logic f7, input int hold);
    clear_tallies(name);
    step(P_FETCH, op, f3, f7, 1'b1, 1'b0);
    step(P_DECODE, op, f3, f7, 1'b1, 1'b1);
    for (int i = 0; i < hold; i++) step(P_FAULT, op, f3, f7, 1'b1, 1'b1);
    check({name, "_fault_sticky"}, fault, 1);
    check({name, "_no_pc_we"}, cnt_pc, 0);
    check({name, "_no_reg_write"}, cnt_rw, 0);
    step(P_RESET, op, f3, f7, 1'b0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired tag=%s", tag);
    $fatal(1);
  end

  initial begin
    alu_tab = '{default: 4'b0000};
    alu_tab[0] = 4'b0000; alu_tab[1] = 4'b0101; alu_tab[2] = 4'b0111; alu_tab[3] = 4'b1000;
    alu_tab[4] = 4'b0100; alu_tab[5] = 4'b0110; alu_tab[6] = 4'b0011; alu_tab[7] = 4'b0010;
    alu_tab[8] = 4'b0001; alu_tab[13] = 4'b1001;

    for (int i = 0; i < 3; i++) step(P_RESET, 7'd0, 3'd0, 1'b0, 1'b1, 1'b1);

    run_instr("add", OP_R, 3'b000, 1'b0, 0, 0, 1'b0, 4);
    check("add_alu", last_alu, 4'b0000);
    run_instr("load_w3", OP_LOAD, 3'b010, 1'b0, 0, 3, 1'b0, 8);
    check("load_mem_reg", last_mr, 1'b1);
    run_instr("store", OP_STORE, 3'b010, 1'b0, 0, 1, 1'b0, 5);
    run_instr("jal", OP_JAL, 3'b000, 1'b0, 0, 0, 1'b0, 3);
    check("jal_next_sel", last_ns, 2'b10);
    run_instr("sub_noise", OP_R, 3'b000, 1'b1, 2, 0, 1'b1, 6);
    check("sub_alu", last_alu, 4'b0001);
    run_instr("srai", OP_I, 3'b101, 1'b1, 0, 0, 1'b0, 4);
    check("srai_alu", last_alu, 4'b1001);
    run_instr("slli_f7", OP_I, 3'b001, 1'b1, 1, 0, 1'b1, 5);
    check("slli_alu", last_alu, 4'b0101);
    run_instr("branch", OP_BRANCH, 3'b001, 1'b0, 0, 0, 1'b1, 3);
    check("branch_alu", last_alu, 4'b0001);
    run_instr("jalr", OP_JALR, 3'b000, 1'b0, 0, 0, 1'b0, 3);
    run_instr("lui", OP_LUI, 3'b011, 1'b0, 0, 0, 1'b0, 4);
    check("lui_opa", last_opa, 2'b10);
    run_instr("auipc", OP_AUIPC, 3'b000, 1'b0, 0, 0, 1'b0, 4);
    run_instr("sltu", OP_R, 3'b011, 1'b0, 0, 0, 1'b0, 4);
    check("sltu_alu", last_alu, 4'b1000);
    run_instr("store_noise", OP_STORE, 3'b000, 1'b0, 1, 2, 1'b1, 7);

    fault_run("illegal_op", 7'b1111111, 3'b000, 1'b0, 20);
    run_instr("after_fault", OP_R, 3'b111, 1'b0, 0, 0, 1'b0, 4);
    fault_run("illegal_r_f7", OP_R, 3'b001, 1'b1, 3);

    clear_tallies("midrst");
    step(P_FETCH, OP_LOAD, 3'b010, 1'b0, 1'b1, 1'b0);
    step(P_DECODE, OP_LOAD, 3'b010, 1'b0, 1'b0, 1'b0);
    step(P_EXEC, OP_LOAD, 3'b010, 1'b0, 1'b0, 1'b0);
    step(P_MEM, OP_LOAD, 3'b010, 1'b0, 1'b0, 1'b0);
    step(P_RESET, OP_LOAD, 3'b010, 1'b0, 1'b0, 1'b1);
    step(P_RESET, OP_LOAD, 3'b010, 1'b0, 1'b0, 1'b1);
    check("midrst_no_reg_write", cnt_rw, 0);
    check("midrst_no_pc_we", cnt_pc, 0);
    run_instr("after_midrst", OP_LUI, 3'b000, 1'b0, 0, 0, 1'b0, 4);

`ifdef MULTICYCLE_CTRL_TIMEOUT_EN
    run_instr("fetch_ready_at_max", OP_I, 3'b000, 1'b0, MAXW, 0, 1'b0, 8);
    run_instr("load_ready_at_max", OP_LOAD, 3'b000, 1'b0, 0, MAXW, 1'b0, 9);
    clear_tallies("fetch_timeout");
    for (int i = 0; i <= MAXW; i++) step(P_FETCH, OP_I, 3'b000, 1'b0, 1'b0, 1'b0);
    step(P_FAULT, OP_I, 3'b000, 1'b0, 1'b0, 1'b0);
    check("fetch_timeout_fault", fault, 1);
    step(P_RESET, OP_I, 3'b000, 1'b0, 1'b0, 1'b0);
    clear_tallies("mem_timeout");
    step(P_FETCH, OP_STORE, 3'b000, 1'b0, 1'b1, 1'b0);
    step(P_DECODE, OP_STORE, 3'b000, 1'b0, 1'b0, 1'b0);
    step(P_EXEC, OP_STORE, 3'b000, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i <= MAXW; i++) step(P_MEM, OP_STORE, 3'b000, 1'b0, 1'b0, 1'b0);
    step(P_FAULT, OP_STORE, 3'b000, 1'b0, 1'b0, 1'b0);
    check("mem_timeout_fault", fault, 1);
    step(P_RESET, OP_STORE, 3'b000, 1'b0, 1'b0, 1'b0);
`else
    run_instr("fetch_long_wait", OP_I, 3'b110, 1'b0, 20, 0, 1'b0, 24);
    run_instr("load_long_wait", OP_LOAD, 3'b000, 1'b0, 0, 12, 1'b0, 17);
`endif
    run_instr("final_add", OP_R, 3'b000, 1'b0, 0, 0, 1'b0, 4);

    exp_valid = 1'b0;
    @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
